// File: rtl/ready_link_rx.sv
// 2P-side link receiver: takes the 1P board's UART frames, debounces the local
// ready button and produces the game-start level plus the received number.
module ready_link_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TIMEOUT_CYC  = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic       BTN_2P,
  output logic       READY_2P,
  output logic       RUN_IN,
  output logic [3:0] NUM,
  output logic       FRAME_ERR
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rxd_s1, r_rxd_s2, r_btn_s1, r_btn_s2;
  logic [DW-1:0]   r_db_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_done, r_stop_ok, r_remote;
  logic [TW-1:0]   r_to_cnt;
  logic            w_cnt_clr, w_shift_en, w_stop_smp, w_valid;

  // Two-flop synchronizers, reset to the idle line levels
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_rxd_s1 <= RXD;
      r_rxd_s2 <= r_rxd_s1;
      r_btn_s1 <= BTN_2P;
      r_btn_s2 <= r_btn_s1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_db_cnt <= '0;
      READY_2P <= 1'b0;
    end else if (r_btn_s2 != READY_2P) begin
      if (r_db_cnt == DB_LAST) begin
        READY_2P <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_rxd_s2) w_state_nxt = START;
      end
      START: begin
        if (r_bit_cnt == HALF_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rxd_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_cnt_clr   = 1'b1;
          w_stop_smp  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame is judged one edge after the stop sample, from registered data
  assign w_valid = r_done && r_stop_ok && (r_shift[7:5] == 3'b101) &&
                   (r_shift[3:0] <= 4'd9);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_stop_ok <= 1'b0;
      r_remote  <= 1'b0;
      r_to_cnt  <= '0;
      NUM       <= 4'h0;
      FRAME_ERR <= 1'b0;
      RUN_IN    <= 1'b0;
    end else begin
      r_bit_cnt <= w_cnt_clr ? '0 : r_bit_cnt + BW'(1);
      if (r_state == IDLE) r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift_en) r_shift <= {r_rxd_s2, r_shift[7:1]};
      r_done <= w_stop_smp;
      if (w_stop_smp) r_stop_ok <= r_rxd_s2;
      FRAME_ERR <= r_done && !w_valid;
      // A valid frame wins over a simultaneous timeout expiry
      if (w_valid) begin
        r_remote <= r_shift[4];
        r_to_cnt <= '0;
      end else begin
        if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TW'(1);
        if (r_to_cnt >= TO_LAST) r_remote <= 1'b0;
      end
      if (w_valid && r_shift[4] && READY_2P) NUM <= r_shift[3:0];
      RUN_IN <= r_remote && READY_2P;
    end
  end

endmodule

// File: tb/tb_ready_link_rx.sv
// Directed bench for ready_link_rx with small sim parameters; frame vectors are
// table-driven, debounce/timeout/reset corners are hand sequences.
module tb_ready_link_rx;

  logic       CLK = 1'b0;
  logic       RST, RXD, BTN_2P;
  logic       READY_2P, RUN_IN, FRAME_ERR;
  logic [3:0] NUM;

  int n_chk  = 0;
  int n_fail = 0;
  int n_errp = 0;

  ready_link_rx #(.CLKS_PER_BIT(8), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(1000)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .BTN_2P(BTN_2P),
    .READY_2P(READY_2P), .RUN_IN(RUN_IN), .NUM(NUM), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (FRAME_ERR === 1'b1) n_errp++;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       err;
    logic [3:0] num;
    logic       run;
  } vec_t;

  vec_t vecs[7];

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    tick(8);
  endtask

  // Returns just after the T+1 edge, where FRAME_ERR/NUM reflect the frame
  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    RXD = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hB7, 1'b1, 1'b0, 4'd7, 1'b1};
    vecs[1] = '{8'hBC, 1'b1, 1'b1, 4'd7, 1'b1};
    vecs[2] = '{8'h37, 1'b1, 1'b1, 4'd7, 1'b1};
    vecs[3] = '{8'hB5, 1'b0, 1'b1, 4'd7, 1'b1};
    vecs[4] = '{8'hA3, 1'b1, 1'b0, 4'd7, 1'b0};
    vecs[5] = '{8'hB9, 1'b1, 1'b0, 4'd9, 1'b1};
    vecs[6] = '{8'hBA, 1'b1, 1'b1, 4'd9, 1'b1};

    RST = 1'b1; RXD = 1'b1; BTN_2P = 1'b0;
    tick(3);
    chk("rst_ready", READY_2P, 1'b0);
    chk("rst_run", RUN_IN, 1'b0);
    chk("rst_num", NUM, 4'h0);
    chk("rst_ferr", FRAME_ERR, 1'b0);
    RST = 1'b0;
    tick(2);

    // Bounce 1,0,1,0 then hold: 2 sync edges + 4 stable edges
    BTN_2P = 1'b1; tick(1);
    BTN_2P = 1'b0; tick(1);
    BTN_2P = 1'b1; tick(1);
    BTN_2P = 1'b0; tick(1);
    chk("bounce_ready_low", READY_2P, 1'b0);
    BTN_2P = 1'b1;
    tick(5);
    chk("deb_before", READY_2P, 1'b0);
    tick(1);
    chk("deb_rise", READY_2P, 1'b1);
    tick(2);

    for (int i = 0; i < 7; i++) begin
      send_byte(vecs[i].data, vecs[i].stop);
      chk($sformatf("v%0d_ferr", i), FRAME_ERR, vecs[i].err);
      chk($sformatf("v%0d_num", i), NUM, vecs[i].num);
      tick(1);
      chk($sformatf("v%0d_run", i), RUN_IN, vecs[i].run);
      chk($sformatf("v%0d_ferr_end", i), FRAME_ERR, 1'b0);
      tick(3);
    end

    // Back-to-back frames, one-bit stop, no idle gap
    send_byte(8'hB4, 1'b1);
    chk("b2b_num1", NUM, 4'd4);
    send_byte(8'hB6, 1'b1);
    chk("b2b_num2", NUM, 4'd6);
    tick(2);

    // Short low glitch on idle line: false start, no error
    RXD = 1'b0; tick(3);
    RXD = 1'b1; tick(20);
    chk("glitch_errs", n_errp, 4);
    chk("glitch_num", NUM, 4'd6);
    chk("glitch_run", RUN_IN, 1'b1);

    // Timeout after the last valid frame
    send_byte(8'hB8, 1'b1);
    chk("to_num", NUM, 4'd8);
    tick(999);
    chk("to_run_before", RUN_IN, 1'b1);
    tick(2);
    chk("to_run_after", RUN_IN, 1'b0);
    chk("to_num_hold", NUM, 4'd8);

    // Reset during DATA bit 3 of 8'hB2
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RXD = 1'b0; tick(3);
    RST = 1'b1; tick(2);
    RXD = 1'b1; tick(1);
    chk("midrst_num", NUM, 4'h0);
    chk("midrst_ready", READY_2P, 1'b0);
    RST = 1'b0;
    tick(20);
    chk("midrst_ready_back", READY_2P, 1'b1);
    send_byte(8'hB2, 1'b1);
    chk("midrst_ferr", FRAME_ERR, 1'b0);
    chk("midrst_num2", NUM, 4'd2);
    tick(1);
    chk("midrst_run", RUN_IN, 1'b1);

    // Button release: READY drops, RUN_IN one cycle later, NUM holds
    BTN_2P = 1'b0;
    tick(6);
    chk("rel_ready", READY_2P, 1'b0);
    chk("rel_run_still", RUN_IN, 1'b1);
    tick(1);
    chk("rel_run", RUN_IN, 1'b0);
    chk("rel_num", NUM, 4'd2);

    chk("total_ferr_cycles", n_errp, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
